// File: rtl/framebuffer_pingpong_if.sv
// Bus bundle for framebuffer_pingpong: pixel write port, swap and row
// request strobes, serial row output and status flags.
//   master : frame source / driver_controller side
//   slave  : framebuffer_pingpong side
//   test_mode exists only when FB_TEST_PATTERN_EN is defined.
interface framebuffer_pingpong_if #(
   parameter int NB_DRIVERS = 30
);
   logic                  wr_en;
   logic [11:0]           wr_addr;
   logic [15:0]           wr_data;
   logic                  wr_swap;
   logic                  row_req;
`ifdef FB_TEST_PATTERN_EN
   logic                  test_mode;
`endif
   logic [NB_DRIVERS-1:0] framebuffer_dat;
   logic                  framebuffer_valid;
   logic                  framebuffer_sync;
   logic [2:0]            row_idx;
   logic                  busy;
   logic                  swap_pending;
   logic                  swap_done;

   modport master (
`ifdef FB_TEST_PATTERN_EN
      output test_mode,
`endif
      output wr_en, wr_addr, wr_data, wr_swap, row_req,
      input  framebuffer_dat, framebuffer_valid, framebuffer_sync,
      input  row_idx, busy, swap_pending, swap_done
   );

   modport slave (
`ifdef FB_TEST_PATTERN_EN
      input  test_mode,
`endif
      input  wr_en, wr_addr, wr_data, wr_swap, row_req,
      output framebuffer_dat, framebuffer_valid, framebuffer_sync,
      output row_idx, busy, swap_pending, swap_done
   );
endinterface

// File: rtl/framebuffer_pingpong.sv
// Double-buffered RGB565 pixel store feeding driver_controller. Writes land
// in the back bank; rows stream from the front bank one bit per driver per
// clock, MSB first of the 48-bit expanded pixel, LED NB_LEDS-1 down to 0.
// Banks swap only at frame boundaries.
// Ports:
//   clk_33 : 33 MHz clock
//   nrst   : asynchronous active-low reset
//   bus    : framebuffer_pingpong_if.slave (wr_*, row_req, outputs, flags)
// Optional: FB_TEST_PATTERN_EN adds bus.test_mode (diagonal test pattern).
module framebuffer_pingpong #(
   parameter int NB_DRIVERS   = 30,
   parameter int NB_LEDS      = 16,
   parameter int NB_MULTIPLEX = 8
) (
   input  logic                         clk_33,
   input  logic                         nrst,
   framebuffer_pingpong_if.slave        bus
);
   localparam int LW = $clog2(NB_LEDS);
   localparam int MW = $clog2(NB_MULTIPLEX);
   localparam int DW = 12 - MW - LW;
   localparam int AW = 1 + MW + LW;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

   logic [1:0]    r_state;
   logic          r_front;
   logic          r_pending;
   logic          r_sync;
   logic [MW-1:0] r_row;
   logic [MW-1:0] r_next;
   logic [LW-1:0] r_led;
   logic [5:0]    r_bit;

   logic [DW-1:0] w_drv;
   logic [MW-1:0] w_mux;
   logic [LW-1:0] w_led;
   logic          w_wr_ok;
   logic [AW-1:0] w_wr_addr;
   logic          w_valid;
   logic          w_last_bit;
   logic          w_end;
   logic          w_swap;
   logic          w_rd_en;
   logic [LW-1:0] w_rd_led;
   logic [AW-1:0] w_rd_addr;
   logic          w_tp_on;
   logic [15:0]   w_tp_pix;
   logic [NB_DRIVERS-1:0] w_dat;

   assign w_drv     = bus.wr_addr[11 -: DW];
   assign w_mux     = bus.wr_addr[LW +: MW];
   assign w_led     = bus.wr_addr[LW-1:0];
   assign w_wr_ok   = bus.wr_en && !r_pending
                    && (int'(w_drv) < NB_DRIVERS);
   assign w_wr_addr = {~r_front, w_mux, w_led};

   assign w_valid    = (r_state == S_STREAM);
   assign w_last_bit = w_valid && (r_bit == 6'd47);
   assign w_end      = w_last_bit && (r_led == '0);

   // Swap at the end of the last row of a frame, or right away while
   // idle before any row of the frame has been streamed.
   assign w_swap = r_pending
      && ((w_end && (r_row == MW'(NB_MULTIPLEX - 1)))
       || ((r_state == S_IDLE) && (r_next == '0)));

   // The next LED word is read on the last bit so the registered RAM
   // output changes exactly at the word boundary with no gap.
   assign w_rd_en   = (r_state == S_FETCH)
                    || (w_last_bit && (r_led != '0));
   assign w_rd_led  = (r_state == S_FETCH) ? r_led : r_led - LW'(1);
   assign w_rd_addr = {r_front, r_row, w_rd_led};

`ifdef FB_TEST_PATTERN_EN
   logic r_test;

   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         r_test <= 1'b0;
      end else if ((r_state == S_IDLE) && bus.row_req) begin
         r_test <= bus.test_mode;
      end
   end

   assign w_tp_on  = r_test;
   assign w_tp_pix = (int'(w_rd_led) == int'(r_row)) ? 16'hFFFF : 16'h0000;
`else
   assign w_tp_on  = 1'b0;
   assign w_tp_pix = 16'h0000;
`endif

   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_next  <= '0;
         r_led   <= '0;
         r_bit   <= '0;
         r_sync  <= 1'b0;
      end else begin
         r_sync <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.row_req) begin
                  r_state <= S_FETCH;
                  r_row   <= r_next;
                  r_led   <= LW'(NB_LEDS - 1);
               end
            end
            S_FETCH: begin
               r_state <= S_STREAM;
               r_bit   <= '0;
               r_sync  <= (r_row == '0);
            end
            S_STREAM: begin
               if (r_bit == 6'd47) begin
                  r_bit <= '0;
                  if (r_led == '0) begin
                     r_state <= S_IDLE;
                     r_next  <= (r_row == MW'(NB_MULTIPLEX - 1))
                              ? '0 : r_row + MW'(1);
                  end else begin
                     r_led <= r_led - LW'(1);
                  end
               end else begin
                  r_bit <= r_bit + 6'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         r_front   <= 1'b0;
         r_pending <= 1'b0;
      end else if (w_swap) begin
         r_front   <= ~r_front;
         r_pending <= 1'b0;
      end else if (bus.wr_swap) begin
         r_pending <= 1'b1;
      end
   end

   for (genvar g = 0; g < NB_DRIVERS; g++) begin : g_drv
      logic [15:0] r_mem [0:(2**AW)-1];
      logic [15:0] r_rd;
      logic [47:0] w_word;

      always_ff @(posedge clk_33) begin
         if (w_wr_ok && (w_drv == DW'(g))) begin
            r_mem[w_wr_addr] <= bus.wr_data;
         end
         if (w_rd_en) begin
            r_rd <= w_tp_on ? w_tp_pix : r_mem[w_rd_addr];
         end
      end

      // RGB565 -> 3 x 16 bits by replicating each field's MSBs
      assign w_word = {
         r_rd[15:11], r_rd[15:11], r_rd[15:11], r_rd[15],
         r_rd[10:5],  r_rd[10:5],  r_rd[10:7],
         r_rd[4:0],   r_rd[4:0],   r_rd[4:0],   r_rd[4]
      };

      assign w_dat[g] = w_valid & w_word[6'd47 - r_bit];
   end

   assign bus.framebuffer_dat   = w_dat;
   assign bus.framebuffer_valid = w_valid;
   assign bus.framebuffer_sync  = r_sync;
   assign bus.row_idx           = r_row;
   assign bus.busy              = (r_state != S_IDLE);
   assign bus.swap_pending      = r_pending;
   assign bus.swap_done         = w_swap;
endmodule

// File: tb/tb_framebuffer_pingpong.sv
// Directed bench for framebuffer_pingpong: a bank model predicts every
// serial row into a queue which is popped while framebuffer_valid is high.
module tb_framebuffer_pingpong;
   logic clk  = 1'b0;
   logic nrst = 1'b0;

   always #5 clk = ~clk;

   framebuffer_pingpong_if #(.NB_DRIVERS(30)) bus ();

   framebuffer_pingpong dut (
      .clk_33 (clk),
      .nrst   (nrst),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [15:0] m_mem [2][30][8][16];
   int          m_front = 0;
   int          m_pend  = 0;
   logic [30:0] q [$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [47:0] exp565(input logic [15:0] p);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = p[15:11];
      g = p[10:5];
      b = p[4:0];
      return {r, r, r, r[4], g, g, g[5:2], b, b, b, b[4]};
   endfunction

   task automatic model_wr(input int d, input int m, input int l,
                           input logic [15:0] data);
      if (d < 30 && m_pend == 0) m_mem[1 - m_front][d][m][l] = data;
   endtask

   task automatic wr(input int d, input int m, input int l,
                     input logic [15:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = {5'(d), 3'(m), 4'(l)};
      bus.wr_data = data;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      model_wr(d, m, l, data);
   endtask

   task automatic push_row(input int row);
      logic [47:0] w [30];
      logic [30:0] v;
      for (int l = 15; l >= 0; l--) begin
         for (int d = 0; d < 30; d++) w[d] = exp565(m_mem[m_front][d][row][l]);
         for (int b = 47; b >= 0; b--) begin
            for (int d = 0; d < 30; d++) v[d] = w[d][b];
            v[30] = (row == 0 && l == 15 && b == 47);
            q.push_back(v);
         end
      end
   endtask

   task automatic swap_idle(input bit w, input int d, input int m,
                            input int l, input logic [15:0] data);
      bus.wr_swap = 1'b1;
      if (w) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = {5'(d), 3'(m), 4'(l)};
         bus.wr_data = data;
      end
      @(negedge clk);
      chk("pend_before_swap", bus.swap_pending, 0);
      @(posedge clk); #1;
      bus.wr_swap = 1'b0;
      bus.wr_en   = 1'b0;
      if (w) model_wr(d, m, l, data);
      @(negedge clk);
      chk("pend_set", bus.swap_pending, 1);
      chk("swap_done_idle", bus.swap_done, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("pend_cleared", bus.swap_pending, 0);
      chk("swap_done_pulse", bus.swap_done, 0);
      m_front = 1 - m_front;
      @(posedge clk); #1;
   endtask

   task automatic run_row(input int row, input int req2, input int swp);
      int fv, nv, bf, sd, nu, esd;
      fv = -1; nv = 0; bf = -1; sd = -1; nu = 0;
      push_row(row);
      bus.row_req = 1'b1;
      for (int c = 1; c < 1000 && bf < 0; c++) begin
         @(posedge clk); #1;
         bus.row_req = (c == req2);
         bus.wr_swap = (c == swp);
         @(negedge clk);
         if (c == 1) begin
            chk("row_idx", bus.row_idx, row);
            chk("pend_at_start", bus.swap_pending, m_pend);
         end
         if (bus.swap_done) sd = c;
         if (bus.framebuffer_valid) begin
            if (fv < 0) fv = c;
            nv++;
            if (q.size() > 0)
               chk("dat_sync", {bus.framebuffer_sync, bus.framebuffer_dat},
                   q.pop_front());
            else
               nu++;
         end else begin
            chk("dat_idle", {bus.framebuffer_sync, bus.framebuffer_dat}, 0);
         end
         if (!bus.busy) bf = c;
      end
      bus.row_req = 1'b0;
      bus.wr_swap = 1'b0;
      chk("first_valid", fv, 2);
      chk("n_valid", nv, 768);
      chk("busy_fall", bf, 770);
      chk("q_underflow", nu, 0);
      chk("q_left", q.size(), 0);
      if (swp > 0) m_pend = 1;
      esd = (row == 7 && m_pend != 0) ? 769 : -1;
      chk("swap_done_cycle", sd, esd);
      if (esd > 0) begin
         m_front = 1 - m_front;
         m_pend  = 0;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_after_row", bus.busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      bus.row_req = 1'b0;
      bus.wr_swap = 1'b0;
      bus.wr_en   = 1'b0;
      nrst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          {bus.framebuffer_dat, bus.framebuffer_valid, bus.framebuffer_sync,
           bus.row_idx, bus.busy, bus.swap_pending, bus.swap_done}, 0);
      @(posedge clk); #1;
      nrst = 1'b1;
      m_front = 0;
      m_pend  = 0;
      q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_swap = 1'b0;
      bus.row_req = 1'b0;
`ifdef FB_TEST_PATTERN_EN
      bus.test_mode = 1'b0;
`endif
      do_reset();
      @(posedge clk); #1;

      for (int p = 0; p < 2; p++) begin
         for (int d = 0; d < 30; d++)
            for (int m = 0; m < 8; m++)
               for (int l = 0; l < 16; l++)
                  wr(d, m, l, 16'h0000);
         swap_idle(1'b0, 0, 0, 0, 16'h0000);
      end

      run_row(0, 0, 0);
      do_reset();

      wr(29, 0, 15, 16'h001F);
      swap_idle(1'b1, 0, 0, 15, 16'hF800);
      run_row(0, 100, 0);
      run_row(1, 0, 0);
      run_row(2, 0, 0);
      run_row(3, 0, 50);
      wr(0, 0, 15, 16'h07E0);
      run_row(4, 0, 0);
      run_row(5, 0, 200);
      run_row(6, 0, 0);
      run_row(7, 0, 0);
      wr(30, 0, 14, 16'hFFFF);
      run_row(0, 0, 0);

      run_row(1, 0, 10);
      for (int r = 2; r < 8; r++) run_row(r, 0, 0);

      bus.row_req = 1'b1;
      @(posedge clk); #1;
      bus.row_req = 1'b0;
      repeat (301) @(posedge clk);
      #2;
      chk("valid_before_abort", bus.framebuffer_valid, 1);
      nrst = 1'b0;
      #1;
      chk("async_abort",
          {bus.framebuffer_dat, bus.framebuffer_valid, bus.framebuffer_sync,
           bus.row_idx, bus.busy, bus.swap_pending, bus.swap_done}, 0);
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;
      m_front = 0;
      m_pend  = 0;
      q.delete();
      @(posedge clk); #1;
      run_row(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
